booth_accumulator: RTL and testbench

Signed accumulation stage directly downstream of the combinational 4x4 Booth multiplier (`booth_driver`). It consumes the 8-bit signed product `Z` one term per handshake and sums `N_TERMS` consecutive products into a wider accumulator. It presents the finished dot-product with a valid/ready handshake, then restarts for the next group.

---
 rtl/booth_accumulator.sv | 110 +++++++++++
 tb/tb_booth_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_accumulator.sv
// Signed accumulator for Booth multiplier products: sums N_TERMS terms per group, then holds the result.
// Optional saturation is enabled by defining BOOTH_ACC_SAT_EN; otherwise adds wrap and overflow stays 0.
module booth_accumulator #(
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_sext
            if (gi < 8) begin : g_low
                assign prod_ext[gi] = prod[gi];
            end else begin : g_high
                assign prod_ext[gi] = prod[7];
            end
        end
    endgenerate

    assign sum = acc_reg + prod_ext;

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic add_ovf;

    // Same-sign operands with a sign flip in the sum: clamp toward the operand sign.
    always_comb begin
        add_ovf  = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_reg[ACC_W-1]);
        acc_next = sum;
        if (add_ovf) begin
            acc_next = acc_reg[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        ovf_next = ovf_reg | add_ovf;
    end
`else
    assign acc_next = sum;
    assign ovf_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else if (clear) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        acc_reg <= acc_next;
                        ovf_reg <= ovf_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACCUM;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        ovf_reg   <= 1'b0;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);
    assign acc_out   = acc_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_booth_accumulator.sv
// Scoreboard bench for booth_accumulator: a 16-bit default instance and an 8-bit saturation/wrap instance.
module tb_booth_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a, overflow_a;
    logic [7:0]  prod_a;
    logic [15:0] acc_out_a;
    logic        clear_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, overflow_b;
    logic [7:0]  prod_b;
    logic [7:0]  acc_out_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    int   m_acc[2];
    int   m_cnt[2];
    bit   m_ovf[2];

    always #5 clk = ~clk;

    booth_accumulator #(.ACC_W(16), .N_TERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .prod(prod_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .acc_out(acc_out_a),
        .overflow(overflow_a)
    );

    booth_accumulator #(.ACC_W(8), .N_TERMS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .prod(prod_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .acc_out(acc_out_b),
        .overflow(overflow_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int obs_acc(input bit b);
        return b ? int'($signed(acc_out_b)) : int'($signed(acc_out_a));
    endfunction
    function automatic int obs_valid(input bit b);
        return b ? int'(out_valid_b) : int'(out_valid_a);
    endfunction
    function automatic int obs_ready(input bit b);
        return b ? int'(in_ready_b) : int'(in_ready_a);
    endfunction
    function automatic int obs_ovf(input bit b);
        return b ? int'(overflow_b) : int'(overflow_a);
    endfunction

    // Reference add at width w: clamps with saturation enabled, otherwise wraps modulo 2^w.
    function automatic int model_add(input int s, input int w, output bit hit);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        int t;
`ifdef BOOTH_ACC_SAT_EN
        hit = (s > mx) || (s < mn);
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
`else
        hit = 1'b0;
        t = s & ((1 << w) - 1);
        if (t > mx) t -= (1 << w);
        return t;
`endif
    endfunction

    task automatic drive(input bit b, input bit clr, input bit v, input int p, input bit rdy);
        if (b) begin
            clear_b = clr; in_valid_b = v; prod_b = 8'(p); out_ready_b = rdy;
        end else begin
            clear_a = clr; in_valid_a = v; prod_a = 8'(p); out_ready_a = rdy;
        end
    endtask

    task automatic model_reset(input bit b);
        m_acc[b] = 0;
        m_cnt[b] = 0;
        m_ovf[b] = 1'b0;
    endtask

    task automatic term(input bit b, input int p, input bit v);
        bit   h;
        exp_t e;
        drive(b, 1'b0, v, p, 1'b0);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 1'b0, p, 1'b0);
        if (v) begin
            m_acc[b] = model_add(m_acc[b] + p, b ? 8 : 16, h);
            m_ovf[b] = m_ovf[b] | h;
            m_cnt[b]++;
            if (m_cnt[b] == 4) begin
                e.acc = m_acc[b];
                e.ovf = m_ovf[b];
                if (b) q_b.push_back(e);
                else   q_a.push_back(e);
                model_reset(b);
            end
        end
    endtask

    task automatic expect_result(input bit b, input string tag, input bit lat);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (obs_valid(b) == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (obs_valid(b) == 0) begin
            check_eq({tag, "_timeout"}, 0, 1);
            return;
        end
        if (lat) check_eq({tag, "_latency"}, waited, 0);
        if ((b ? q_b.size() : q_a.size()) == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
            return;
        end
        if (b) e = q_b.pop_front();
        else   e = q_a.pop_front();
        check_eq({tag, "_acc"}, obs_acc(b), e.acc);
        check_eq({tag, "_ovf"}, obs_ovf(b), int'(e.ovf));
        $display("result %s dut%0d acc %0d ovf %0d (exp %0d/%0d)", tag, b, obs_acc(b), obs_ovf(b),
                 e.acc, e.ovf);
    endtask

    task automatic take(input bit b, input string tag);
        drive(b, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check_eq({tag, "_take_valid"}, obs_valid(b), 0);
        check_eq({tag, "_take_ready"}, obs_ready(b), 1);
        check_eq({tag, "_take_acc"}, obs_acc(b), 0);
        check_eq({tag, "_take_ovf"}, obs_ovf(b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gaps[7] = '{1, 0, 0, 1, 0, 1, 1};
        int neg_terms[4] = '{64, 64, -56, -56};
        model_reset(0);
        model_reset(1);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 1'b0, 0, 1'b0);
        #2;
        check_eq("rst_acc", obs_acc(0), 0);
        check_eq("rst_valid", obs_valid(0), 0);
        check_eq("rst_ready", obs_ready(0), 1);
        check_eq("rst_ovf_b", obs_ovf(1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Products of (4,6), (7,7), (7,-5), (-6,-6).
        term(0, 24, 1); term(0, 49, 1); term(0, -35, 1); term(0, 36, 1);
        expect_result(0, "dflt", 1);
        check_eq("dflt_const", obs_acc(0), 74);

        // Result must hold under backpressure and ignore terms offered in HOLD.
        drive(0, 1'b0, 1'b1, 99, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_acc", obs_acc(0), 74);
            check_eq("bp_ready", obs_ready(0), 0);
            check_eq("bp_valid", obs_valid(0), 1);
        end
        take(0, "bp");

        term(0, 24, 1); term(0, 49, 1);
        @(negedge clk);
        check_eq("partial_acc", obs_acc(0), m_acc[0]);
        drive(0, 1'b1, 1'b1, -35, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        model_reset(0);
        @(negedge clk);
        check_eq("clr_acc", obs_acc(0), 0);
        check_eq("clr_ready", obs_ready(0), 1);
        term(0, 1, 1); term(0, 1, 1); term(0, 1, 1);
        @(negedge clk);
        check_eq("clr_3terms_valid", obs_valid(0), 0);
        term(0, 1, 1);
        expect_result(0, "clr", 1);
        check_eq("clr_const", obs_acc(0), 4);
        take(0, "clr");

        for (int i = 0; i < 7; i++) term(0, 10, gaps[i]);
        expect_result(0, "gaps", 1);
        check_eq("gaps_const", obs_acc(0), 40);
        take(0, "gaps");

        // clear beats out_ready and a concurrent term while holding a result.
        term(0, 1, 1); term(0, 2, 1); term(0, 3, 1); term(0, 4, 1);
        expect_result(0, "hold", 1);
        drive(0, 1'b1, 1'b1, 5, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check_eq("hold_clr_valid", obs_valid(0), 0);
        check_eq("hold_clr_acc", obs_acc(0), 0);
        for (int i = 0; i < 4; i++) term(0, 2, 1);
        expect_result(0, "post_clr", 1);
        take(0, "post_clr");

        // 8-bit instance: positive and negative overflow, then recovery from a clamped value.
        for (int i = 0; i < 4; i++) term(1, 64, 1);
        expect_result(1, "sat_pos", 1);
`ifdef BOOTH_ACC_SAT_EN
        check_eq("sat_pos_const", obs_acc(1), 127);
        check_eq("sat_pos_flag", obs_ovf(1), 1);
`else
        check_eq("wrap_pos_const", obs_acc(1), 0);
        check_eq("wrap_pos_flag", obs_ovf(1), 0);
`endif
        take(1, "sat_pos");
        for (int i = 0; i < 4; i++) term(1, -56, 1);
        expect_result(1, "sat_neg", 1);
        take(1, "sat_neg");
        for (int i = 0; i < 4; i++) term(1, neg_terms[i], 1);
        expect_result(1, "sat_back", 1);
        take(1, "sat_back");

        // Asynchronous reset mid-group, sampled before any further clock edge.
        term(0, 24, 1); term(0, 49, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_acc", obs_acc(0), 0);
        check_eq("arst_valid", obs_valid(0), 0);
        check_eq("arst_ready", obs_ready(0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);

        check_eq("sb_drain", q_a.size() + q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
